// File: rtl/tick_pwm_pkg.sv
// tick_pwm_pkg
// Shared definitions for the tick-driven PWM generator and its edge detector.
//
// Contents:
//   DefaultWidth - default width of the period/duty registers and tick counter
//   ZeroBit      - reset value for single-bit registers
//   pwmOpE       - what the PWM datapath does on a given Clk cycle
//   decodeOp     - priority decode of enable/tick/period state into a pwmOpE
//
// Optional build macro used by this slice: TICK_PWM_SYNC_EN (see tick_edge_detect).

package tick_pwm_pkg;

  localparam int DefaultWidth = 16;

  localparam logic ZeroBit = 1'b0;

  // One operation per Clk cycle, chosen by decodeOp in priority order:
  //   OpStopped    - Enable low: counter cleared, shadows copied into actives
  //   OpHold       - enabled, no tick: counter holds, output re-evaluated
  //   OpIdleReload - tick while the active period is zero: reload only
  //   OpWrap       - tick on the last count of a period: boundary reload
  //   OpAdvance    - any other tick: count up
  typedef enum logic [2:0] {
    OpStopped,
    OpHold,
    OpIdleReload,
    OpWrap,
    OpAdvance
  } pwmOpE;

  // Enable outranks everything, then the tick itself, then the zero-period
  // case (which must never be treated as a wrap), then the wrap compare.
  function automatic pwmOpE decodeOp(
    input logic enable,
    input logic tick,
    input logic periodZero,
    input logic atWrap
  );
    pwmOpE op;
    op = OpStopped;
    if (!enable) begin
      op = OpStopped;
    end else if (!tick) begin
      op = OpHold;
    end else if (periodZero) begin
      op = OpIdleReload;
    end else if (atWrap) begin
      op = OpWrap;
    end else begin
      op = OpAdvance;
    end
    return op;
  endfunction

endpackage

// File: rtl/tick_pwm_gen_edge_detect.sv
// tick_edge_detect
// Turns the divider's ClkOutput into a one-Clk tick pulse on each rising edge.
// Reusable by any consumer of the divider output.
//
// Build option:
//   TICK_PWM_SYNC_EN defined   - TickIn first passes a 2-flop synchronizer
//                                (reset to 0), for a divider in another clock
//                                domain; tick-to-output latency is 3 Clk cycles.
//   TICK_PWM_SYNC_EN undefined - TickIn feeds the edge detector directly and
//                                must already be synchronous to Clk.
//
// Ports:
//   Clk    in   system clock
//   Reset  in   asynchronous active-low reset
//   TickIn in   divided clock level
//   Tick   out  combinational pulse, high for the one cycle in which the
//               (optionally synchronized) level is high but was low last cycle

module tick_edge_detect
  import tick_pwm_pkg::*;
(
  input  logic Clk,
  input  logic Reset,
  input  logic TickIn,
  output logic Tick
);

  logic tickLevel;
  logic tickPrev;

`ifdef TICK_PWM_SYNC_EN
  logic syncMeta;
  logic syncOut;

  // Two-stage synchronizer for a TickIn launched from a foreign clock.
  // Both stages clear on reset so no phantom tick appears after release.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      syncMeta <= ZeroBit;
      syncOut  <= ZeroBit;
    end else begin
      syncMeta <= TickIn;
      syncOut  <= syncMeta;
    end
  end

  assign tickLevel = syncOut;
`else
  assign tickLevel = TickIn;
`endif

  // Previous level, tracked every cycle regardless of Enable downstream, so a
  // level held high produces exactly one tick.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      tickPrev <= ZeroBit;
    end else begin
      tickPrev <= tickLevel;
    end
  end

  // Left combinational so the PWM registers react on the same edge that first
  // samples the level high.
  assign Tick = tickLevel & ~tickPrev;

endmodule

// File: rtl/tick_pwm_gen.sv
// tick_pwm_gen
// PWM generator clocked by ticks from the frequency divider. Period and duty
// are counted in ticks and written through shadow registers; the active copies
// only change at a period boundary, while stopped, or while the active period
// is zero, so a running waveform never sees a half-applied update.
//
// Waveform: with period P>0 and duty D, PwmOut is high for min(D,P) of every
// P ticks (D=0 constant low, D>=P constant high). PeriodDone pulses for one
// Clk at every wrap. P=0 keeps the output low and never signals PeriodDone.
//
// Build option: TICK_PWM_SYNC_EN adds a 2-flop TickIn synchronizer inside
// tick_edge_detect (tick-to-output latency 3 Clk instead of 1).
//
// Parameters:
//   WIDTH        width of period, duty and tick counter (default 16)
//
// Ports:
//   Clk          in   system clock (divider runs on the same clock)
//   Reset        in   asynchronous active-low reset
//   TickIn       in   divider ClkOutput, rising edge = one tick
//   Din          in   configuration data
//   ConfigPeriod in   load Din into the period shadow
//   ConfigDuty   in   load Din into the duty shadow
//   Enable       in   run/stop control
//   PwmOut       out  registered PWM output
//   PeriodDone   out  one-Clk pulse at each period wrap

module tick_pwm_gen
  import tick_pwm_pkg::*;
#(
  parameter int WIDTH = DefaultWidth
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             TickIn,
  input  logic [WIDTH-1:0] Din,
  input  logic             ConfigPeriod,
  input  logic             ConfigDuty,
  input  logic             Enable,
  output logic             PwmOut,
  output logic             PeriodDone
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic             tick;
  logic [WIDTH-1:0] periodShadow;
  logic [WIDTH-1:0] dutyShadow;
  logic [WIDTH-1:0] periodActive;
  logic [WIDTH-1:0] dutyActive;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cntInc;
  logic [WIDTH-1:0] periodLast;
  logic             periodZero;
  logic             atWrap;
  pwmOpE            op;

  tick_edge_detect uEdge (
    .Clk    (Clk),
    .Reset  (Reset),
    .TickIn (TickIn),
    .Tick   (tick)
  );

  // cnt stays below periodActive, which is at most 2^WIDTH-1, so the
  // increment cannot overflow. periodLast wraps to all-ones when the period
  // is zero, but that case is decoded ahead of the wrap compare.
  assign cntInc     = cnt + One;
  assign periodLast = periodActive - One;
  assign periodZero = (periodActive == '0);
  assign atWrap     = (cnt == periodLast);

  // Pick this cycle's datapath operation.
  always_comb begin
    op = decodeOp(Enable, tick, periodZero, atWrap);
  end

  // Shadow registers accept writes on any cycle, enabled or not. Asserting
  // both strobes loads the same Din into both.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      periodShadow <= '0;
      dutyShadow   <= '0;
    end else begin
      if (ConfigPeriod) begin
        periodShadow <= Din;
      end
      if (ConfigDuty) begin
        dutyShadow <= Din;
      end
    end
  end

  // Counter, active registers and registered outputs. A shadow write landing
  // on the same edge as a wrap is not seen by that wrap: the active copies
  // take the pre-write shadow values and the new one waits for the next
  // boundary. At a wrap the output is computed from the incoming shadow
  // values because the active copies are being replaced on this same edge.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      periodActive <= '0;
      dutyActive   <= '0;
      cnt          <= '0;
      PwmOut       <= ZeroBit;
      PeriodDone   <= ZeroBit;
    end else begin
      case (op)
        OpStopped: begin
          cnt          <= '0;
          periodActive <= periodShadow;
          dutyActive   <= dutyShadow;
          PwmOut       <= ZeroBit;
          PeriodDone   <= ZeroBit;
        end
        OpHold: begin
          PwmOut     <= !periodZero && (cnt < dutyActive);
          PeriodDone <= ZeroBit;
        end
        OpIdleReload: begin
          cnt          <= '0;
          periodActive <= periodShadow;
          dutyActive   <= dutyShadow;
          PwmOut       <= ZeroBit;
          PeriodDone   <= ZeroBit;
        end
        OpWrap: begin
          cnt          <= '0;
          periodActive <= periodShadow;
          dutyActive   <= dutyShadow;
          PwmOut       <= (periodShadow != '0) && (dutyShadow != '0);
          PeriodDone   <= 1'b1;
        end
        OpAdvance: begin
          cnt        <= cntInc;
          PwmOut     <= (cntInc < dutyActive);
          PeriodDone <= ZeroBit;
        end
        default: begin
          PwmOut     <= ZeroBit;
          PeriodDone <= ZeroBit;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_pwm_gen.sv
// tb_tick_pwm_gen
// Directed bench for tick_pwm_gen in its default build (TickIn synchronous,
// 1-cycle latency). Each tick is a 10-Clk TickIn period (5 high, 5 low).
// Expected waveforms are hand-derived tables, one bit per tick, LSB = first
// tick of the table.

module tb_tick_pwm_gen;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        TickIn;
  logic [15:0] Din;
  logic        ConfigPeriod;
  logic        ConfigDuty;
  logic        Enable;
  logic        PwmOut;
  logic        PeriodDone;

  int errors = 0;
  int checks = 0;

  tick_pwm_gen #(.WIDTH(16)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .TickIn       (TickIn),
    .Din          (Din),
    .ConfigPeriod (ConfigPeriod),
    .ConfigDuty   (ConfigDuty),
    .Enable       (Enable),
    .PwmOut       (PwmOut),
    .PeriodDone   (PeriodDone)
  );

  // 10 ns Clk, rising edges at 5, 15, 25, ...
  initial begin
    forever #5 Clk = ~Clk;
  end

  // Advance to 1 ns after the next rising edge; inputs change and outputs
  // are sampled there.
  task automatic stepClk();
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // One-cycle configuration write.
  task automatic applyStimulus(input logic cp, input logic cd, input logic [15:0] data);
    ConfigPeriod = cp;
    ConfigDuty   = cd;
    Din          = data;
    stepClk();
    ConfigPeriod = 1'b0;
    ConfigDuty   = 1'b0;
  endtask

  // One tick: TickIn high for 5 Clk then low for 5 Clk. Reports the outputs
  // right after the tick edge, the settled PwmOut at the end, and a glitch
  // flag if PeriodDone is seen after the first cycle or PwmOut moves after
  // the second cycle.
  task automatic runTick(output logic pwmFirst, output logic doneFirst,
                         output logic pwmLast, output logic glitch);
    logic prev;
    TickIn = 1'b1;
    stepClk();
    pwmFirst  = PwmOut;
    doneFirst = PeriodDone;
    glitch    = 1'b0;
    prev      = PwmOut;
    for (int i = 1; i < 10; i++) begin
      if (i == 5) TickIn = 1'b0;
      stepClk();
      if (PeriodDone !== 1'b0) glitch = 1'b1;
      if (i >= 2 && PwmOut !== prev) glitch = 1'b1;
      prev = PwmOut;
    end
    pwmLast = PwmOut;
  endtask

  task automatic runTable(input string name, input int n, input logic [15:0] expPwm,
                          input logic [15:0] expDone, input bit checkFirst);
    logic pf, df, pl, gl;
    for (int i = 0; i < n; i++) begin
      runTick(pf, df, pl, gl);
      if (checkFirst) checkOutput($sformatf("%s_t%0d_pwmAtTick", name, i), pf, expPwm[i]);
      checkOutput($sformatf("%s_t%0d_pwm", name, i), pl, expPwm[i]);
      checkOutput($sformatf("%s_t%0d_done", name, i), df, expDone[i]);
      checkOutput($sformatf("%s_t%0d_stable", name, i), gl, 1'b0);
    end
  endtask

  initial begin
    Reset        = 1'b0;
    TickIn       = 1'b0;
    Din          = '0;
    ConfigPeriod = 1'b0;
    ConfigDuty   = 1'b0;
    Enable       = 1'b0;

    // Reset held for 23 ns with TickIn toggling.
    repeat (5) begin
      #4 TickIn = ~TickIn;
    end
    #3;
    checkOutput("resetPwm", PwmOut, 1'b0);
    checkOutput("resetDone", PeriodDone, 1'b0);
    Reset  = 1'b1;
    TickIn = 1'b0;
    stepClk();

    // P=5, D=2 while stopped, then enable.
    applyStimulus(1'b1, 1'b0, 16'd5);
    applyStimulus(1'b0, 1'b1, 16'd2);
    stepClk();
    checkOutput("disabledPwm", PwmOut, 1'b0);
    Enable = 1'b1;
    stepClk();
    checkOutput("firstEnabledPwm", PwmOut, 1'b1);
    checkOutput("firstEnabledDone", PeriodDone, 1'b0);

    // 2 high / 3 low, PeriodDone every 5 ticks.
    runTable("p5d2", 10, 16'h0231, 16'h0210, 1'b1);

    // Duty change mid-period takes effect after the next wrap.
    runTable("midA", 2, 16'h0001, 16'h0000, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'd4);
    runTable("midB", 8, 16'h00BC, 16'h0084, 1'b1);

    // D=0: constant low once the boundary passes.
    applyStimulus(1'b0, 1'b1, 16'd0);
    runTable("d0", 10, 16'h0007, 16'h0210, 1'b0);

    // D=7 > P=5: constant high once the boundary passes.
    applyStimulus(1'b0, 1'b1, 16'd7);
    runTable("d7", 10, 16'h03F0, 16'h0210, 1'b0);

    // P=0: output low and PeriodDone silent after the boundary.
    applyStimulus(1'b1, 1'b0, 16'd0);
    runTable("p0", 10, 16'h000F, 16'h0010, 1'b0);

    // P=3 picked up at the next tick; D=7 keeps it constant high.
    applyStimulus(1'b1, 1'b0, 16'd3);
    runTable("p3", 6, 16'h003F, 16'h0008, 1'b0);

    // Asynchronous reset mid-cycle, right after a wrap.
    TickIn = 1'b1;
    stepClk();
    checkOutput("wrapBeforeResetDone", PeriodDone, 1'b1);
    checkOutput("wrapBeforeResetPwm", PwmOut, 1'b1);
    #3 Reset = 1'b0;
    #1;
    checkOutput("asyncResetPwm", PwmOut, 1'b0);
    checkOutput("asyncResetDone", PeriodDone, 1'b0);
    #2;
    Reset  = 1'b1;
    TickIn = 1'b0;
    stepClk();
    checkOutput("postResetPwm", PwmOut, 1'b0);
    runTable("postReset", 2, 16'h0000, 16'h0000, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
